// File: rtl/ckp_gen.sv
// ckp_gen - crankshaft/camshaft signal generator.
//
// Produces a toothed-wheel CKP waveform (TOOTH_NUM positions, of which the
// last GAP_NUM are missing) and a cam level that toggles once per crank
// revolution. The tooth period is given in clocks and is double-buffered:
// writes land in a shadow register, and the active period reloads from it
// only at tooth boundaries. This keeps every tooth whole.
//
// Optional feature (macro CKP_GEN_ACCEL_EN): adds a signed delta_in port.
// At each boundary with no period write since the previous boundary, the
// period becomes shadow + delta_in, saturated to [2, 2^PERIOD_WIDTH-1].
// The shadow register takes the same value, so the period ramps linearly.
//
// Ports:
//   clk        module clock
//   rst        asynchronous reset, active-low
//   ena        run request (level); sampled at start and at tooth boundaries
//   period_wr  one-clock strobe, loads period_in into the shadow register
//   period_in  tooth period in clocks (1 is clamped to 2, 0 stops the wheel)
//   delta_in   signed per-tooth period increment (CKP_GEN_ACCEL_EN only)
//   cap        CKP waveform, registered (falling edge = main edge)
//   cam        cam phase level
//   tooth_cnt  current tooth index 0..TOOTH_NUM-1
//   rev_strobe one-clock pulse in the first cycle of tooth 0
//   running    generator active
//   dbg_state  FSM state (0 = IDLE, 1 = RUN)
module ckp_gen #(
  parameter int TOOTH_NUM    = 60,
  parameter int GAP_NUM      = 2,
  parameter int TCNT_WIDTH   = 6,
  parameter int PERIOD_WIDTH = 24
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           ena,
  input  logic                           period_wr,
  input  logic [PERIOD_WIDTH-1:0]        period_in,
`ifdef CKP_GEN_ACCEL_EN
  input  logic signed [PERIOD_WIDTH-1:0] delta_in,
`endif
  output logic                           cap,
  output logic                           cam,
  output logic [TCNT_WIDTH-1:0]          tooth_cnt,
  output logic                           rev_strobe,
  output logic                           running,
  output logic                           dbg_state
);

  localparam logic [PERIOD_WIDTH-1:0] P_ONE  = PERIOD_WIDTH'(1);
  localparam logic [PERIOD_WIDTH-1:0] P_MIN  = PERIOD_WIDTH'(2);
  localparam logic [TCNT_WIDTH-1:0]   T_LAST = TCNT_WIDTH'(TOOTH_NUM - 1);
  localparam logic [TCNT_WIDTH-1:0]   T_GAP  = TCNT_WIDTH'(TOOTH_NUM - GAP_NUM);

  typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

  state_t                  r_state, w_state_nxt;
  logic [PERIOD_WIDTH-1:0] r_shadow, w_shadow_nxt;
  logic [PERIOD_WIDTH-1:0] r_active, w_active_nxt;
  logic [PERIOD_WIDTH-1:0] r_pcnt, w_pcnt_nxt;
  logic [TCNT_WIDTH-1:0]   r_tooth, w_tooth_nxt;
  logic                    r_cam, w_cam_nxt;
  logic                    r_rev, w_rev_nxt;
  logic                    r_run, w_run_nxt;
  logic                    r_cap, w_cap_nxt;

  logic [PERIOD_WIDTH-1:0] w_wr_val;
  logic [PERIOD_WIDTH-1:0] w_reload;
  logic                    w_start;
  logic                    w_boundary;

  // A period of 1 cannot produce a high and a low phase, so it becomes 2.
  assign w_wr_val   = (period_in == P_ONE) ? P_MIN : period_in;
  assign w_start    = (r_state == S_IDLE) && ena && (r_shadow != '0);
  assign w_boundary = (r_state == S_RUN) && (r_pcnt == r_active - P_ONE);

`ifdef CKP_GEN_ACCEL_EN
  logic                           r_wr_seen, w_wr_seen_nxt;
  logic signed [PERIOD_WIDTH+1:0] w_sum;
  logic [PERIOD_WIDTH-1:0]        w_ramp;

  // Two guard bits hold the full range of unsigned shadow plus signed delta.
  // The top bit flags a negative sum and the next bit flags an overflow.
  always_comb begin
    w_sum  = $signed({2'b00, r_shadow}) +
             $signed({{2{delta_in[PERIOD_WIDTH-1]}}, delta_in});
    w_ramp = w_sum[PERIOD_WIDTH-1:0];
    if (w_sum[PERIOD_WIDTH+1])                 w_ramp = P_MIN;
    else if (w_sum[PERIOD_WIDTH])              w_ramp = '1;
    else if (w_sum[PERIOD_WIDTH-1:0] < P_MIN)  w_ramp = P_MIN;
    // An explicit write since the last boundary overrides the ramp.
    w_reload = r_wr_seen ? r_shadow : w_ramp;
  end

  always_comb begin
    w_wr_seen_nxt = r_wr_seen;
    if (w_start || w_boundary) w_wr_seen_nxt = 1'b0;
    // A write that shares the boundary edge counts toward the next boundary.
    if (period_wr)             w_wr_seen_nxt = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_wr_seen <= 1'b0;
    else      r_wr_seen <= w_wr_seen_nxt;
  end
`else
  assign w_reload = r_shadow;
`endif

  always_comb begin
    w_state_nxt  = r_state;
    w_shadow_nxt = r_shadow;
    w_active_nxt = r_active;
    w_pcnt_nxt   = r_pcnt;
    w_tooth_nxt  = r_tooth;
    w_cam_nxt    = r_cam;
    w_rev_nxt    = 1'b0;
    w_run_nxt    = r_run;

    case (r_state)
      S_IDLE: begin
        if (w_start) begin
          w_state_nxt  = S_RUN;
          w_active_nxt = r_shadow;
          w_pcnt_nxt   = '0;
          w_tooth_nxt  = '0;
          w_rev_nxt    = 1'b1;
          w_run_nxt    = 1'b1;
        end
      end
      S_RUN: begin
        if (w_boundary) begin
`ifdef CKP_GEN_ACCEL_EN
          if (!r_wr_seen) w_shadow_nxt = w_ramp;
`endif
          w_pcnt_nxt = '0;
          if (!ena || (w_reload == '0)) begin
            w_state_nxt = S_IDLE;
            w_run_nxt   = 1'b0;
            w_tooth_nxt = '0;
          end else begin
            w_active_nxt = w_reload;
            if (r_tooth == T_LAST) begin
              w_tooth_nxt = '0;
              w_cam_nxt   = ~r_cam;
              w_rev_nxt   = 1'b1;
            end else begin
              w_tooth_nxt = r_tooth + TCNT_WIDTH'(1);
            end
          end
        end else begin
          w_pcnt_nxt = r_pcnt + P_ONE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase

    // The write lands after the reload decision, so a write that shares
    // the boundary edge first takes effect at the following boundary.
    if (period_wr) w_shadow_nxt = w_wr_val;

    // Decoding the next state keeps cap aligned with tooth_cnt and pcnt.
    w_cap_nxt = w_run_nxt && (w_tooth_nxt < T_GAP) &&
                (w_pcnt_nxt < (w_active_nxt >> 1));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= S_IDLE;
      r_shadow <= '0;
      r_active <= '0;
      r_pcnt   <= '0;
      r_tooth  <= '0;
      r_cam    <= 1'b0;
      r_rev    <= 1'b0;
      r_run    <= 1'b0;
      r_cap    <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_shadow <= w_shadow_nxt;
      r_active <= w_active_nxt;
      r_pcnt   <= w_pcnt_nxt;
      r_tooth  <= w_tooth_nxt;
      r_cam    <= w_cam_nxt;
      r_rev    <= w_rev_nxt;
      r_run    <= w_run_nxt;
      r_cap    <= w_cap_nxt;
    end
  end

  assign cap        = r_cap;
  assign cam        = r_cam;
  assign tooth_cnt  = r_tooth;
  assign rev_strobe = r_rev;
  assign running    = r_run;
  assign dbg_state  = (r_state == S_RUN);

endmodule
